fetch_stage: RTL and testbench

- Fetch stage: holds the PC, issues instruction-memory requests and fills the IF/ID pipeline register.
- Consumes the redirect produced by the EX-stage branch resolution (PC_sel, branch_PC).
- Feeds the decode stage.
- Tolerates variable-latency instruction memory with one outstanding request; discards responses made stale by a redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_hold_buf.sv | 47 ++++
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : IDLE (nothing outstanding), BUSY (one request outstanding),
//                   HOLD (response buffered while stalled), DROP (stale request outstanding)
//   NOP_INSTR     : instruction placed in IF/ID for bubbles and flushes
//   PC_INC        : PC step between sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-entry {pc, instr} buffer that parks an instruction
// response arriving while decode is stalled.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_load           capture i_pc / i_instr, mark valid
//   i_clear          drop the buffered entry
//   i_pc, i_instr    entry to capture
//   o_valid          buffer holds an entry
//   o_pc, o_instr    buffered entry
module fetch_hold_buf #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [INS_W-1:0] i_instr,
  output logic             o_valid,
  output logic [PC_W-1:0]  o_pc,
  output logic [INS_W-1:0] o_instr
);

  logic             r_valid;
  logic [PC_W-1:0]  r_pc;
  logic [INS_W-1:0] r_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, issues instruction-memory requests (one
// outstanding at most) and fills the IF/ID pipeline register. Responses made
// stale by an EX redirect or by reset are discarded.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall                    hold PC advance and IF/ID contents
//   PC_sel, branch_PC        EX redirect request and its target (truncated to PC_W)
//   imem_req_valid/addr      fetch request, imem_req_ready accepts it
//   imem_rsp_valid/data      in-order response, one per accepted request
//   if_id_pc/instr/valid     IF/ID pipeline register
//   fetch_misalign           sticky misaligned-redirect flag (only with the macro below)
// Optional feature: define FETCH_MISALIGN_TRAP_EN to add fetch_misalign and
// block further requests after a redirect to a non word-aligned target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      PC_W     = 9,
  parameter int unsigned      INS_W    = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PC_sel,
  input  logic [31:0]      branch_PC,
  output logic             imem_req_valid,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [INS_W-1:0] if_id_instr,
  output logic             if_id_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic             fetch_misalign
`endif
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_req_pc;

  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_next;
  logic             w_rsp_take;
  logic             w_accept;
  logic             w_trap;
  logic             w_buf_load;
  logic             w_buf_clear;
  logic             w_buf_valid;
  logic [PC_W-1:0]  w_buf_pc;
  logic [INS_W-1:0] w_buf_instr;
  logic             w_unused_branch_hi;

  assign w_target           = branch_PC[PC_W-1:0];
  assign w_unused_branch_hi = ^branch_PC[31:PC_W];
  assign w_pc_next          = r_pc + PC_W'(PC_INC);

  // Response consumed straight into IF/ID this cycle.
  assign w_rsp_take = (r_state == BUSY) && imem_rsp_valid && !stall && !PC_sel;

  assign imem_req_valid = !reset && !PC_sel && !w_trap &&
                          ((r_state == IDLE) || w_rsp_take);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_buf_load  = !reset && (r_state == BUSY) && imem_rsp_valid && stall && !PC_sel;
  assign w_buf_clear = (r_state == HOLD) && (PC_sel || !stall);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (PC_sel && (branch_PC[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign w_trap         = r_misalign;
  assign fetch_misalign = r_misalign;
`else
  assign w_trap = 1'b0;
`endif

  fetch_hold_buf #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_req_pc),
    .i_instr (imem_rsp_data),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );

  // pc steps to req_pc + 4 at acceptance rather than at the response; while
  // BUSY/HOLD it therefore already equals req_pc + 4, which lets a request be
  // issued in the same cycle the previous response is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      // A request still in flight at reset has its late response swallowed.
      r_state  <= (((r_state == BUSY) || (r_state == DROP)) && !imem_rsp_valid) ? DROP : IDLE;
    end else begin
      if (w_accept) begin
        r_req_pc <= r_pc;
        r_pc     <= w_pc_next;
      end
      if (PC_sel) begin
        r_pc <= w_target;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= BUSY;
        end
        BUSY: begin
          if (PC_sel) begin
            r_state <= imem_rsp_valid ? IDLE : DROP;
          end else if (imem_rsp_valid) begin
            if (stall)         r_state <= HOLD;
            else if (w_accept) r_state <= BUSY;
            else               r_state <= IDLE;
          end
        end
        HOLD: begin
          if (PC_sel || !stall) r_state <= IDLE;
        end
        DROP: begin
          if (imem_rsp_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // IF/ID: reset > redirect flush > stall hold > load available word > bubble.
  always_ff @(posedge clk) begin
    if (reset || PC_sel) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= INS_W'(NOP_INSTR);
    end else if (!stall) begin
      if ((r_state == BUSY) && imem_rsp_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= r_req_pc;
        if_id_instr <= imem_rsp_data;
      end else if ((r_state == HOLD) && w_buf_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= w_buf_pc;
        if_id_instr <= w_buf_instr;
      end else begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= INS_W'(NOP_INSTR);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned     PC_W     = 9;
  localparam int unsigned     INS_W    = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [31:0]     NOP      = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, stall, PC_sel;
  logic [31:0]      branch_PC;
  logic             imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [PC_W-1:0]  imem_req_addr;
  logic [INS_W-1:0] imem_rsp_data;
  logic [PC_W-1:0]  if_id_pc;
  logic [INS_W-1:0] if_id_instr;
  logic             if_id_valid;
  logic             fetch_misalign_obs;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_W     (PC_W),
    .INS_W    (INS_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PC_sel         (PC_sel),
    .branch_PC      (branch_PC),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign_obs)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign_obs = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, the one in-flight request (wanted or stale),
  // a parked word, and the IF/ID contents.
  bit [PC_W-1:0] m_pc, m_wpc, m_hpc, m_ipc;
  bit            m_wait, m_stale, m_held, m_misal, m_v;
  bit [31:0]     m_hins, m_ins;

  // Memory environment: one pending response, delivered lat cycles after acceptance.
  bit            mem_busy;
  int            mem_cnt;
  int            lat;
  bit [PC_W-1:0] mem_addr;

  logic            obs_reqv, obs_ifv, obs_mis;
  logic [PC_W-1:0] obs_addr, obs_ifpc;
  logic [31:0]     obs_ifins;

  // One clock cycle: inputs (other than the response) are set by the caller.
  task automatic step();
    bit            rv, consume, e_reqv, acc_m, acc_d;
    bit [PC_W-1:0] tgt, d_addr;
    bit [31:0]     rdata;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA000_0000 | 32'(mem_addr);
      end
    end
    #1;
    rv      = imem_rsp_valid;
    rdata   = imem_rsp_data;
    tgt     = branch_PC[PC_W-1:0];
    consume = m_wait && rv && !stall && !PC_sel;
    e_reqv  = !reset && !PC_sel && !m_misal && ((!m_wait && !m_stale && !m_held) || consume);

    chk("req_valid", imem_req_valid, e_reqv);
    if (e_reqv) chk("req_addr", imem_req_addr, m_pc);
    chk("if_id_valid", if_id_valid, m_v);
    chk("if_id_instr", if_id_instr, m_ins);
    if (m_v) chk("if_id_pc", if_id_pc, m_ipc);
    if (MIS_EN) chk("misalign", fetch_misalign_obs, m_misal);

    obs_reqv  = imem_req_valid;
    obs_addr  = imem_req_addr;
    obs_ifv   = if_id_valid;
    obs_ifpc  = if_id_pc;
    obs_ifins = if_id_instr;
    obs_mis   = fetch_misalign_obs;

    acc_d  = imem_req_valid && imem_req_ready;
    d_addr = imem_req_addr;
    acc_m  = e_reqv && imem_req_ready;

    if (reset) begin
      m_stale = (m_wait || m_stale) && !rv;
      m_wait  = 1'b0;
      m_held  = 1'b0;
      m_pc    = RESET_PC;
      m_v     = 1'b0;
      m_ipc   = '0;
      m_ins   = NOP;
      m_misal = 1'b0;
    end else begin
      if (PC_sel) begin
        m_v = 1'b0; m_ipc = '0; m_ins = NOP;
      end else if (!stall) begin
        if (m_wait && rv) begin
          m_v = 1'b1; m_ipc = m_wpc; m_ins = rdata;
        end else if (m_held) begin
          m_v = 1'b1; m_ipc = m_hpc; m_ins = m_hins;
        end else begin
          m_v = 1'b0; m_ipc = '0; m_ins = NOP;
        end
      end
      if (m_held && (PC_sel || !stall)) m_held = 1'b0;
      if (m_wait && rv && stall && !PC_sel) begin
        m_held = 1'b1; m_hpc = m_wpc; m_hins = rdata;
      end
      if (rv) begin
        m_wait = 1'b0; m_stale = 1'b0;
      end else if (PC_sel && m_wait) begin
        m_wait = 1'b0; m_stale = 1'b1;
      end
      if (acc_m) begin
        m_wait = 1'b1; m_wpc = m_pc; m_pc = m_pc + 9'd4;
      end
      if (PC_sel) begin
        m_pc = tgt;
        if (MIS_EN && (branch_PC[1:0] != 2'b00)) m_misal = 1'b1;
      end
    end

    if (rv) mem_busy = 1'b0;
    if (acc_d) begin
      mem_busy = 1'b1; mem_cnt = lat; mem_addr = d_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit [7:0] stall_pat;
    reset = 1'b1; stall = 1'b0; PC_sel = 1'b0; branch_PC = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    m_pc = RESET_PC; m_wait = 0; m_stale = 0; m_held = 0; m_misal = 0;
    m_v = 0; m_ipc = '0; m_ins = NOP; m_wpc = '0; m_hpc = '0; m_hins = '0;
    mem_busy = 0; mem_cnt = 0; lat = 1; mem_addr = '0;

    step();                                   // reset cycle
    chk("lit_rst_reqv", obs_reqv, 1'b0);
    chk("lit_rst_ins", obs_ifins, NOP);
    reset = 1'b0;

    step(); chk("lit_s0_addr", obs_addr, 9'h000); chk("lit_s0_reqv", obs_reqv, 1'b1);
    step(); chk("lit_s1_addr", obs_addr, 9'h004);
    step(); chk("lit_s2_addr", obs_addr, 9'h008);
    chk("lit_s2_ifv", obs_ifv, 1'b1); chk("lit_s2_ifpc", obs_ifpc, 9'h000);
    step(); step();                           // requests 0x00C, 0x010

    stall = 1'b1;                             // response for 0x010 parked
    repeat (3) step();
    chk("lit_hold_ifpc", obs_ifpc, 9'h00C); chk("lit_hold_reqv", obs_reqv, 1'b0);
    stall = 1'b0;
    step();
    lat = 4;
    step();
    chk("lit_rel_ifpc", obs_ifpc, 9'h010);
    chk("lit_rel_ins", obs_ifins, 32'hA000_0010);
    chk("lit_rel_addr", obs_addr, 9'h014);

    PC_sel = 1'b1; branch_PC = 32'h40;        // redirect with response 3 cycles away
    step();
    PC_sel = 1'b0;
    step(); chk("lit_flush_v", obs_ifv, 1'b0); chk("lit_flush_ins", obs_ifins, NOP);
    step(); step();                           // stale response arrives and is dropped
    lat = 1;
    step(); chk("lit_br_addr", obs_addr, 9'h040); chk("lit_br_reqv", obs_reqv, 1'b1);
    step();

    PC_sel = 1'b1; branch_PC = 32'h18;        // redirect while response arrives
    step();
    PC_sel = 1'b0;
    step(); step(); step();                   // 0x018, 0x01C, 0x020 requested
    stall = 1'b1;
    step();                                   // 0x020 parked
    PC_sel = 1'b1; branch_PC = 32'h80;
    step();
    PC_sel = 1'b0; stall = 1'b0;
    step();
    chk("lit_hold_br_v", obs_ifv, 1'b0); chk("lit_hold_br_addr", obs_addr, 9'h080);

    PC_sel = 1'b1; branch_PC = 32'h1FC;
    step();
    PC_sel = 1'b0;
    step();                                   // fetch 0x1FC
    step(); chk("lit_wrap_addr", obs_addr, 9'h000);
    step(); chk("lit_wrap_ifpc", obs_ifpc, 9'h1FC);
    PC_sel = 1'b1; branch_PC = 32'h0000_0204;
    step();
    PC_sel = 1'b0;
    lat = 3;
    step(); chk("lit_trunc_addr", obs_addr, 9'h004);

    reset = 1'b1;                             // reset with a request in flight
    step();
    reset = 1'b0;
    step(); step();
    lat = 1;
    step(); chk("lit_rst_mid_addr", obs_addr, 9'h000); chk("lit_rst_mid_reqv", obs_reqv, 1'b1);

    lat = 2;
    stall_pat = 8'b0110_0100;
    for (int i = 0; i < 8; i++) begin
      stall = stall_pat[i];
      step();
    end
    stall = 1'b0;
    repeat (3) step();

`ifdef FETCH_MISALIGN_TRAP_EN
    PC_sel = 1'b1; branch_PC = 32'h42;
    step();
    PC_sel = 1'b0;
    step(); chk("lit_mis_set", obs_mis, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lit_mis_noreq", obs_reqv, 1'b0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("lit_mis_clr", obs_mis, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
